// File: rtl/de_int_ctrl.sv
// Drawing-engine interrupt controller: toggle-edge capture into sticky status,
// masking, holdoff coalescing of the host interrupt, and a small config port.
module de_int_ctrl #(
   parameter int NSRC   = 4,
   parameter int HOLD_W = 8
) (
   input  logic              de_clk,
   input  logic              de_rst,
   input  logic [NSRC-1:0]   src_tog,
   input  logic              cfg_wr,
   input  logic              cfg_rd,
   input  logic [1:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic [31:0]       cfg_rdata,
   output logic              cfg_rvalid,
   output logic              int_out,
   output logic              int_pend
);

   typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

   state_t            state;
   logic [NSRC-1:0]   tog_q;
   logic [NSRC-1:0]   ev;
   logic [NSRC-1:0]   status;
   logic [NSRC-1:0]   mask;
   logic [NSRC-1:0]   w1c;
   logic [HOLD_W-1:0] holdoff;
   logic [HOLD_W-1:0] cnt;
   logic [15:0]       evcnt;
   logic [4:0]        ev_num;
   logic [16:0]       evcnt_sum;
   logic [31:0]       rd_mux;
   logic              unused_wdata;

   assign unused_wdata = &{1'b0, cfg_wdata};

   assign ev       = src_tog ^ tog_q;
   assign int_pend = |(status & mask);
   assign w1c      = (cfg_wr && cfg_addr == 2'd0) ? cfg_wdata[NSRC-1:0] : '0;

   always_comb begin
      ev_num = '0;
      for (int i = 0; i < NSRC; i++)
         ev_num = ev_num + 5'(ev[i]);
   end

   assign evcnt_sum = {1'b0, evcnt} + 17'(ev_num);

   always_comb begin
      rd_mux = '0;
      case (cfg_addr)
         2'd0: rd_mux[NSRC-1:0]   = status;
         2'd1: rd_mux[NSRC-1:0]   = mask;
         2'd2: rd_mux[HOLD_W-1:0] = holdoff;
         2'd3: rd_mux[15:0]       = evcnt;
         default: rd_mux = '0;
      endcase
   end

   // tog_q follows src_tog even in reset so release never fakes an event.
   always_ff @(posedge de_clk) begin
      tog_q <= src_tog;
      if (de_rst) begin
         status     <= '0;
         mask       <= '0;
         holdoff    <= '0;
         evcnt      <= '0;
         cfg_rdata  <= '0;
         cfg_rvalid <= 1'b0;
      end else begin
         status     <= (status & ~w1c) | ev;
         cfg_rvalid <= cfg_rd;
         if (cfg_rd)
            cfg_rdata <= rd_mux;
         if (cfg_wr && cfg_addr == 2'd1)
            mask <= cfg_wdata[NSRC-1:0];
         if (cfg_wr && cfg_addr == 2'd2)
            holdoff <= cfg_wdata[HOLD_W-1:0];
         if (cfg_wr && cfg_addr == 2'd3)
            evcnt <= '0;
         else if (evcnt_sum[16])
            evcnt <= 16'hFFFF;
         else
            evcnt <= evcnt_sum[15:0];
      end
   end

   // HOLD runs exactly 'holdoff' cycles from the value latched on entry.
   always_ff @(posedge de_clk) begin
      if (de_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         int_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (int_pend) begin
                  state   <= ASSERT;
                  int_out <= 1'b1;
               end
            end
            ASSERT: begin
               if (!int_pend) begin
                  int_out <= 1'b0;
                  if (holdoff == '0) begin
                     state <= IDLE;
                  end else begin
                     state <= HOLD;
                     cnt   <= holdoff;
                  end
               end
            end
            HOLD: begin
               int_out <= 1'b0;
               if (cnt <= HOLD_W'(1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - HOLD_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               int_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_de_int_ctrl.sv
// Bench for de_int_ctrl: directed vector table, hand sequences for holdoff,
// saturation and read/W1C ordering, then random traffic against a reference model.
module tb_de_int_ctrl;

   logic        de_clk = 1'b0;
   logic        de_rst;
   logic [3:0]  src_tog;
   logic        cfg_wr, cfg_rd;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        cfg_rvalid, int_out, int_pend;

   int n_tests = 0;
   int n_fail  = 0;

   de_int_ctrl #(.NSRC(4), .HOLD_W(8)) dut (
      .de_clk(de_clk), .de_rst(de_rst), .src_tog(src_tog),
      .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
      .int_out(int_out), .int_pend(int_pend)
   );

   always #5 de_clk = ~de_clk;

   // reference model: status/mask/etc as plain integers, interrupt as
   // "asserted" flag plus a remaining-holdoff count
   int          m_status, m_mask, m_holdoff, m_evcnt, m_hold;
   bit          m_int, m_rvalid;
   logic [3:0]  m_togq;
   logic [31:0] m_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail < 40)
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int m_read(input logic [1:0] a);
      case (a)
         2'd0: return m_status;
         2'd1: return m_mask;
         2'd2: return m_holdoff;
         default: return m_evcnt;
      endcase
   endfunction

   task automatic model_step();
      logic [3:0] ev;
      int clr;
      bit pend;
      if (de_rst) begin
         m_status = 0; m_mask = 0; m_holdoff = 0; m_evcnt = 0;
         m_hold = 0; m_int = 0; m_rvalid = 0; m_rdata = 0;
         m_togq = src_tog;
         return;
      end
      ev     = src_tog ^ m_togq;
      m_togq = src_tog;
      pend   = (m_status & m_mask) != 0;
      if (cfg_rd) m_rdata = m_read(cfg_addr);
      m_rvalid = cfg_rd;
      if (m_int) begin
         if (!pend) begin
            m_int  = 0;
            m_hold = m_holdoff;
         end
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (pend) begin
         m_int = 1;
      end
      clr = (cfg_wr && cfg_addr == 2'd0) ? int'(cfg_wdata[3:0]) : 0;
      m_status = (m_status & ~clr) | int'(ev);
      if (cfg_wr && cfg_addr == 2'd1) m_mask    = int'(cfg_wdata[3:0]);
      if (cfg_wr && cfg_addr == 2'd2) m_holdoff = int'(cfg_wdata[7:0]);
      if (cfg_wr && cfg_addr == 2'd3) m_evcnt = 0;
      else begin
         m_evcnt = m_evcnt + $countones(ev);
         if (m_evcnt > 65535) m_evcnt = 65535;
      end
   endtask

   task automatic tick();
      @(posedge de_clk);
      model_step();
      #1;
      chk("int_out", 32'(int_out), 32'(m_int));
      chk("int_pend", 32'(int_pend), 32'((m_status & m_mask) != 0));
      chk("cfg_rvalid", 32'(cfg_rvalid), 32'(m_rvalid));
      chk("cfg_rdata", cfg_rdata, m_rdata);
   endtask

   task automatic cyc(input logic wr, input logic rd, input logic [1:0] a, input logic [31:0] d);
      cfg_wr = wr; cfg_rd = rd; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0;
   endtask

   typedef struct {
      logic [3:0]  tog;
      logic        wr, rd;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic        e_int, e_pend, e_rv;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int n;
      bit seen;
      tbl[0]  = '{4'b1010, 1, 0, 2'd1, 32'hF, 0, 0, 0, 32'h0};
      tbl[1]  = '{4'b1011, 0, 0, 2'd0, 32'h0, 0, 1, 0, 32'h0};
      tbl[2]  = '{4'b1011, 0, 1, 2'd0, 32'h0, 1, 1, 1, 32'h1};
      tbl[3]  = '{4'b1011, 1, 0, 2'd0, 32'h1, 1, 0, 0, 32'h0};
      tbl[4]  = '{4'b1011, 0, 0, 2'd0, 32'h0, 0, 0, 0, 32'h0};
      tbl[5]  = '{4'b1011, 0, 1, 2'd3, 32'h0, 0, 0, 1, 32'h1};
      tbl[6]  = '{4'b1011, 1, 1, 2'd3, 32'h0, 0, 0, 1, 32'h1};
      tbl[7]  = '{4'b1011, 0, 1, 2'd3, 32'h0, 0, 0, 1, 32'h0};
      tbl[8]  = '{4'b0011, 1, 0, 2'd0, 32'h8, 0, 1, 0, 32'h0};
      tbl[9]  = '{4'b0011, 0, 1, 2'd0, 32'h0, 1, 1, 1, 32'h8};
      tbl[10] = '{4'b0011, 1, 0, 2'd1, 32'h0, 1, 0, 0, 32'h0};
      tbl[11] = '{4'b0011, 0, 1, 2'd1, 32'h0, 0, 0, 1, 32'h0};
      tbl[12] = '{4'b0011, 1, 0, 2'd1, 32'h8, 0, 1, 0, 32'h0};
      tbl[13] = '{4'b0011, 0, 0, 2'd0, 32'h0, 1, 1, 0, 32'h0};
      tbl[14] = '{4'b0011, 1, 0, 2'd0, 32'hF, 1, 0, 0, 32'h0};
      tbl[15] = '{4'b0011, 0, 0, 2'd0, 32'h0, 0, 0, 0, 32'h0};

      // reset with non-zero toggles, then idle: nothing may appear
      de_rst = 1; src_tog = 4'b1010;
      cfg_wr = 0; cfg_rd = 0; cfg_addr = 0; cfg_wdata = 0;
      tick(); tick();
      chk("reset_int_out", 32'(int_out), 32'h0);
      chk("reset_rvalid", 32'(cfg_rvalid), 32'h0);
      de_rst = 0;
      repeat (20) tick();
      cyc(0, 1, 2'd0, 0); chk("post_reset_status", cfg_rdata, 32'h0);
      cyc(0, 1, 2'd3, 0); chk("post_reset_evcnt", cfg_rdata, 32'h0);

      for (int i = 0; i < 16; i++) begin
         src_tog = tbl[i].tog;
         cyc(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
         chk($sformatf("vec%0d_int", i), 32'(int_out), 32'(tbl[i].e_int));
         chk($sformatf("vec%0d_pend", i), 32'(int_pend), 32'(tbl[i].e_pend));
         chk($sformatf("vec%0d_rvalid", i), 32'(cfg_rvalid), 32'(tbl[i].e_rv));
         if (tbl[i].e_rv) chk($sformatf("vec%0d_rdata", i), cfg_rdata, tbl[i].e_rdata);
      end

      // holdoff: 5 HOLD cycles + 1 IDLE before re-assert; mid-HOLD holdoff write ignored
      cyc(1, 0, 2'd2, 32'd5);
      cyc(1, 0, 2'd1, 32'h1);
      src_tog[0] = ~src_tog[0]; tick(); tick();
      chk("hold_pre_assert", 32'(int_out), 32'h1);
      cyc(1, 0, 2'd0, 32'h1);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 2) src_tog[0] = ~src_tog[0];
         if (i == 3) cyc(1, 0, 2'd2, 32'd2); else tick();
         if (int_out) begin n = i; break; end
      end
      chk("hold_reassert_cycle", 32'(n), 32'd7);
      cyc(1, 0, 2'd0, 32'hF);
      cyc(1, 0, 2'd2, 32'd0);
      repeat (6) tick();

      // W1C and toggle of bit 2 in the same cycle: set wins
      cyc(1, 0, 2'd1, 32'hF);
      src_tog[2] = ~src_tog[2];
      cyc(1, 0, 2'd0, 32'h4);
      cyc(0, 1, 2'd0, 0);
      chk("setwins_status", cfg_rdata, 32'h4);
      chk("setwins_int", 32'(int_out), 32'h1);
      cyc(1, 0, 2'd0, 32'hF);
      repeat (3) tick();

      // masked flood: no interrupt, EVCNT saturates, write clears
      cyc(1, 0, 2'd1, 32'h0);
      cyc(1, 0, 2'd3, 32'h0);
      seen = 0;
      for (int i = 0; i < 16400; i++) begin
         src_tog = ~src_tog;
         tick();
         if (int_out) seen = 1;
      end
      chk("flood_no_int", 32'(seen), 32'h0);
      cyc(0, 1, 2'd3, 0); chk("evcnt_sat", cfg_rdata, 32'hFFFF);
      cyc(1, 0, 2'd3, 0);
      cyc(0, 1, 2'd3, 0); chk("evcnt_clear", cfg_rdata, 32'h0);

      // read-before-W1C ordering
      cyc(1, 0, 2'd0, 32'hF);
      src_tog = src_tog ^ 4'b0110; tick();
      cyc(1, 1, 2'd0, 32'hF);
      chk("rdw1c_rdata", cfg_rdata, 32'h6);
      chk("rdw1c_rvalid", 32'(cfg_rvalid), 32'h1);
      cyc(0, 1, 2'd0, 0); chk("rdw1c_after", cfg_rdata, 32'h0);
      tick(); chk("rvalid_pulse", 32'(cfg_rvalid), 32'h0);

      // reset aborts ASSERT
      cyc(1, 0, 2'd1, 32'hF);
      src_tog[1] = ~src_tog[1]; tick(); tick();
      chk("abort_pre", 32'(int_out), 32'h1);
      de_rst = 1; tick(); de_rst = 0;
      chk("abort_int", 32'(int_out), 32'h0);
      tick();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         de_rst    = ($urandom_range(0, 199) == 0);
         src_tog   = src_tog ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
         cfg_wr    = ($urandom_range(0, 3) == 0);
         cfg_rd    = ($urandom_range(0, 2) == 0);
         cfg_addr  = 2'($urandom);
         cfg_wdata = (cfg_addr == 2'd2) ? 32'($urandom_range(0, 6)) : $urandom;
         tick();
      end
      de_rst = 0; cfg_wr = 0; cfg_rd = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/de_int_ctrl.md
Name: de_int_ctrl

Overview:
- Drawing-engine interrupt controller in the de_clk domain.
- Detects edges on toggle-style event lines from the DE (clip toggle, draw-done toggle, DEB-clear, palette-clear), latches them into a sticky status register, masks them, and drives one host interrupt line.
- Holdoff timer coalesces back-to-back interrupts.
- Small register port supplies configuration and readback to the host-bus decode.

Parameters:
- NSRC, 4, number of toggle event sources (1..8)
- HOLD_W, 8, width of holdoff counter/register

Ports:
- de_clk  in  1  drawing engine clock
- de_rst  in  1  synchronous active-high reset
- src_tog  in  NSRC  toggle event inputs; each transition (either polarity) is one event
- cfg_wr  in  1  register write strobe, one cycle
- cfg_rd  in  1  register read strobe, one cycle
- cfg_addr  in  2  register select: 0 STATUS, 1 MASK, 2 HOLDOFF, 3 EVCNT
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, registered
- cfg_rvalid  out  1  read data valid, one-cycle pulse
- int_out  out  1  host interrupt, active high
- int_pend  out  1  combinational OR of (status & mask)

Behaviour:
- Reset (de_rst=1 at rising de_clk): status=0, mask=0, holdoff=0, evcnt=0, FSM=IDLE, cfg_rdata=0, cfg_rvalid=0, int_out=0; tog_q loads src_tog (not 0), so no spurious event after reset. Reset asserted mid-operation aborts ASSERT/HOLD immediately.
- Edge detect: ev[i] = src_tog[i] ^ tog_q[i]; tog_q <= src_tog every cycle.
- STATUS[NSRC-1:0]: bit set on ev[i]; cleared by write to addr 0 with cfg_wdata[i]=1 (W1C). Set and clear in the same cycle: set wins. Upper bits read 0.
- MASK[NSRC-1:0]: RW; 1 = enabled. int_pend = |(status & mask).
- HOLDOFF[HOLD_W-1:0]: RW. A write takes effect on the next HOLD entry; it does not reload a running count.
- EVCNT[15:0]: adds popcount(ev) each cycle; saturates at 16'hFFFF with no wrap (0xFFFE + 2 gives 0xFFFF). Any write to addr 3 clears it. A clear and an increment in the same cycle: clear wins, result 0.
- Reads: cfg_rd at edge k gives cfg_rdata/cfg_rvalid valid after edge k. A read in the same cycle as a write to the same address returns the pre-write value.
- cfg_rd and cfg_wr both high: both are performed.
- FSM, int_out = (state==ASSERT):
  - IDLE: int_pend=1 -> ASSERT.
  - ASSERT: int_pend=0 -> HOLD with cnt=holdoff, or -> IDLE if holdoff==0.
  - HOLD: int_out=0; cnt decrements each cycle; cnt==1 -> IDLE. HOLD lasts exactly holdoff cycles and ignores int_pend.
  - IDLE is re-entered after HOLD; if int_pend is still 1, ASSERT follows on the next edge.
- Latency:
  - src_tog change before edge k -> status set at edge k -> int_out high after edge k+1.
  - W1C/mask write at edge k dropping int_pend -> int_out low after edge k+1.
- Masking a pending bit while in ASSERT follows the normal deassert path. Unmasking a set bit from IDLE asserts int_out after 1 edge.
- Multiple sources toggling in one cycle: all status bits set; EVCNT adds the count of toggling sources.
- Counter width: cnt is HOLD_W bits, with no underflow (never decremented at 0).

Test Plan:
1. Reset with src_tog=4'b1010, release reset, hold inputs -> status=0, int_out=0, EVCNT=0 for 20 cycles.
2. mask=4'hF, holdoff=0; toggle src_tog[0] before edge 10 -> STATUS reads 4'b0001; int_out high after edge 11; write STATUS=1 at edge 15 -> int_out low after edge 16, FSM IDLE.
3. holdoff=5, mask=1; event, then W1C -> int_out low for exactly 5 cycles; a second event during HOLD sets status but int_out re-rises 2 cycles after HOLD ends (IDLE then ASSERT).
4. W1C of bit 2 in the same cycle src_tog[2] toggles -> bit 2 stays 1, int_out remains/asserts.
5. mask=0; toggle all 4 sources for 16400 cycles -> int_out never asserts; EVCNT reads 16'hFFFF (saturated); write addr 3 -> reads 0.
6. Read STATUS in the same cycle as W1C of 4'hF with status 4'b0110 -> cfg_rdata=32'h6 with cfg_rvalid pulse; next read returns 0.
